ram_burst_reader: RTL and testbench
===================================

# ram_burst_reader

Burst read engine that drives one port of `dual_port_ram` as its client. It accepts a request (start address, length), issues one RAM read per cycle while credit allows, and tracks the fixed RAM read latency. Returned words go into a small output FIFO and are presented on a valid/ready stream with a last-beat marker. It sits between a DMA/consumer block and a RAM port whose write side is owned by another agent.

## Interface
- `ADDR_WIDTH`, 5, RAM address width.
- `DATA_WIDTH`, 32, RAM and stream data width.
- `READ_LANTENCY`, 3, RAM read latency in cycles (≥1); must equal the attached RAM's setting.
- `FIFO_DEPTH`, 4, output FIFO entries (≥2); ≥ `READ_LANTENCY`+1 for full rate.

Ports:
- `i_clk`  in  1  single clock for everything.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_req_valid`  in  1  burst request valid.
- `o_req_ready`  out  1  request accepted when both high.
- `i_req_addr`  in  ADDR_WIDTH  start address.
- `i_req_len`  in  ADDR_WIDTH+1  word count (0 allowed).
- `o_ram_en`  out  1  RAM port enable (read strobe).
- `o_ram_we`  out  1  RAM write enable; tied 0.
- `o_ram_addr`  out  ADDR_WIDTH  RAM read address.
- `i_ram_dout`  in  DATA_WIDTH  RAM read data.
- `o_data_valid`  out  1  output word valid.
- `i_data_ready`  in  1  consumer ready.
- `o_data`  out  DATA_WIDTH  output word.
- `o_data_last`  out  1  marks final word of burst.
- `o_busy`  out  1  high from acceptance until done.
- `o_done`  out  1  one-cycle pulse at burst completion.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: `o_req_ready`=1. On accept, latch address into `addr_q` and length into `remain_q`. Next state:
  - ISSUE if len>0.
  - If len=0, stay IDLE and pulse `o_done` next cycle with no RAM access.
- ISSUE: issue a read (`o_ram_en`=1, `o_ram_addr`=`addr_q`) when inflight + fifo_count − pop_this_cycle < `FIFO_DEPTH`.
  - Per issue: `addr_q`+1 modulo 2^ADDR_WIDTH (wraps 31→0 at default), `remain_q`−1.
  - The issue with `remain_q`=1 is tagged last. Next state DRAIN.
- Inflight tracking: a `READ_LANTENCY`-deep valid/last shift register. Its tail bit writes `i_ram_dout` plus the last tag into the FIFO.
- DRAIN: no issues. Wait until the last-tagged word is popped (valid&ready with `o_data_last`=1). Then pulse `o_done`, return to IDLE.
- Output: `o_data_valid` = FIFO non-empty. `o_data`/`o_data_last` come from the FIFO head. Pop on valid&ready. Data is held stable while valid and not ready.
- `o_busy` = state ≠ IDLE. The FIFO never overflows; the credit rule guarantees this.

## Timing
- Reset (async, immediate) values:
  - State IDLE; `o_req_ready`=1.
  - `o_ram_en`=`o_ram_we`=0; `o_ram_addr`=0.
  - `o_data_valid`=0, `o_data`=0, `o_data_last`=0.
  - `o_busy`=0, `o_done`=0.
  - FIFO and inflight pipeline cleared.
- Reset mid-burst discards all in-flight returns and FIFO contents; no `o_done`.
- Request accepted at edge E: first `o_ram_en` in cycle E+1.
- Read issued in cycle t: the RAM presents data in cycle t+`READ_LANTENCY`, the word is written to the FIFO at the end of that cycle, and `o_data_valid` is earliest in cycle t+`READ_LANTENCY`+1. First-word latency from accept is `READ_LANTENCY`+2 cycles.
- Throughput: 1 word/cycle sustained with `i_data_ready`=1 and `FIFO_DEPTH` ≥ `READ_LANTENCY`+1.
- `o_done` asserts the cycle after the last-word handshake. `o_req_ready` returns the same cycle, so back-to-back bursts are allowed.
- Backpressure: with ready low, issues stop once inflight+count reaches `FIFO_DEPTH`; they resume in the same cycle a pop frees a credit.
- `i_ram_dout` is sampled only on the pipeline tail bit; other cycles are don't-care.

## Test plan
- Preload RAM[i]=0xA000+i; request addr=2, len=4, ready held 1 -> `o_ram_en` for 4 consecutive cycles with addr 2,3,4,5; `o_data` = 0xA002..0xA005 on consecutive cycles, first at accept+5 (`READ_LANTENCY`=3); `o_data_last` on 0xA005; `o_done` one cycle later.
- Request addr=30, len=4 -> reads 30,31,0,1; data 0xA01E, 0xA01F, 0xA000, 0xA001.
- Request addr=0, len=8 with ready low for the first 10 cycles -> exactly 4 reads issued then stall; FIFO holds 0xA000..0xA003; after ready rises, all 8 words arrive in order with no loss or duplication.
- len=0 -> no `o_ram_en`; `o_done` pulses the cycle after accept; `o_data_valid` stays 0.
- Two back-to-back requests (addr 5/len 2, then addr 9/len 3) -> second accepted the cycle `o_done` pulses; output stream 0xA005, 0xA006(last), 0xA009, 0xA00A, 0xA00B(last).
- Assert `i_rst` 2 cycles after accepting len=6 -> all outputs reach reset values immediately; no `o_data_valid` or `o_done` after release; a new request then behaves normally.

Source files
------------

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: credit-limited burst reader of a fixed-latency RAM port feeding a valid/ready stream
module ram_burst_reader #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LANTENCY = 3,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [ADDR_WIDTH:0]   i_req_len,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_dout,
  output logic                  o_data_valid,
  input  logic                  i_data_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_last,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     remain_q, remain_d;
  logic [READ_LANTENCY-1:0] pv_q, pv_d, pl_q, pl_d;
  logic [DATA_WIDTH:0]     mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH:0]     mem_d [FIFO_DEPTH];
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    accept, issue, push, pop, is_last;
  int                      inflight;
  assign o_req_ready  = state_q == IDLE;
  assign accept       = i_req_valid && o_req_ready;
  assign o_data_valid = cnt_q != '0;
  assign pop          = o_data_valid && i_data_ready;
  assign push         = pv_q[READ_LANTENCY-1];
  assign is_last      = remain_q == (ADDR_WIDTH+1)'(1);
  assign {o_data_last, o_data} = mem_q[rd_q];
  assign issue        = (state_q == ISSUE) && (inflight + int'(cnt_q) < FIFO_DEPTH + int'(pop));
  assign o_ram_en     = issue;
  assign o_ram_we     = 1'b0;
  assign o_ram_addr   = addr_q;
  assign o_busy       = state_q != IDLE;
  assign o_done       = done_q;
  // reads issued but not yet landed in the FIFO
  always_comb begin
    inflight = 0;
    for (int i = 0; i < READ_LANTENCY; i++) inflight = inflight + int'(pv_q[i]);
  end
  // burst control: accept, issue with address wrap, drain until the last word leaves
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    if (accept) begin
      addr_d   = i_req_addr;
      remain_d = i_req_len;
      state_d  = i_req_len != '0 ? ISSUE : IDLE;
      done_d   = i_req_len == '0;
    end
    if (issue) begin
      addr_d   = addr_q + 1'b1;
      remain_d = remain_q - 1'b1;
      state_d  = is_last ? DRAIN : ISSUE;
    end
    if (state_q == DRAIN && pop && o_data_last) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  // latency pipeline carrying valid and last tag alongside each outstanding read
  always_comb begin
    pv_d    = '0;
    pl_d    = '0;
    pv_d[0] = issue;
    pl_d[0] = issue && is_last;
    for (int i = 1; i < READ_LANTENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      pl_d[i] = pl_q[i-1];
    end
  end
  // output FIFO: pipeline tail pushes, consumer handshake pops
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_q] = {pl_q[READ_LANTENCY-1], i_ram_dout};
      wr_d        = wr_q == PW'(FIFO_DEPTH-1) ? '0 : wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q == PW'(FIFO_DEPTH-1) ? '0 : rd_q + 1'b1;
  end
  // state registers; reset drops every outstanding read and buffered word
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      pv_q     <= '0;
      pl_q     <= '0;
      mem_q    <= '{default: '0};
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      pv_q     <= pv_d;
      pl_q     <= pl_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: randomized and directed bursts checked against a queue-based reference model
module tb_ram_burst_reader;
  localparam int AW = 5, DW = 32, L = 3, D = 4;
  logic clk = 1'b0, rst;
  logic i_req_valid, o_req_ready, o_ram_en, o_ram_we;
  logic [AW-1:0] i_req_addr, o_ram_addr;
  logic [AW:0] i_req_len;
  logic [DW-1:0] i_ram_dout, o_data;
  logic o_data_valid, i_data_ready, o_data_last, o_busy, o_done;
  ram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LANTENCY(L), .FIFO_DEPTH(D)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_len(i_req_len), .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr), .i_ram_dout(i_ram_dout), .o_data_valid(o_data_valid),
    .i_data_ready(i_data_ready), .o_data(o_data), .o_data_last(o_data_last),
    .o_busy(o_busy), .o_done(o_done));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, passed = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask
  // RAM with a 3-cycle read latency; junk on cycles with no read returning
  logic [DW-1:0] ram [32];
  logic [AW-1:0] a1, a2;
  logic v1, v2;
  initial for (int i = 0; i < 32; i++) ram[i] = 32'hA000 + i;
  always @(posedge clk) begin
    a1 <= o_ram_addr; v1 <= o_ram_en;
    a2 <= a1;         v2 <= v1;
    i_ram_dout <= v2 ? ram[a2] : $urandom;
  end
  // reference model state
  logic [DW:0] expq[$];
  logic [AW-1:0] addrq[$];
  int availq[$];
  int outstanding = 0;
  bit done_pend = 0, busy_m = 0;
  int en_cnt, first_en, last_en, first_vld, vld_cnt, pop_cnt, done_cyc, done_cnt;
  logic [DW-1:0] first_data, last_data;
  task automatic clear_stats();
    en_cnt = 0; first_en = -1; last_en = -1; first_vld = -1; vld_cnt = 0;
    pop_cnt = 0; done_cyc = -1; done_cnt = 0; first_data = '0; last_data = '0;
  endtask
  // per-cycle compare against the model
  always @(negedge clk) begin
    bit pop_now, nd, nb, exp_en, exp_vld;
    logic [DW:0] e;
    if (rst) begin
      expq.delete(); addrq.delete(); availq.delete();
      outstanding = 0; done_pend = 0; busy_m = 0;
    end else begin
      pop_now = o_data_valid && i_data_ready;
      nd = 0; nb = busy_m;
      chk("ram_we", o_ram_we, 0);
      chk("done", o_done, done_pend);
      chk("busy", o_busy, busy_m);
      chk("req_ready", o_req_ready, !busy_m);
      exp_en  = addrq.size() > 0 && (outstanding - int'(pop_now) < D);
      exp_vld = availq.size() > 0 && availq[0] <= cyc;
      chk("ram_en", o_ram_en, exp_en);
      chk("data_valid", o_data_valid, exp_vld);
      if (o_ram_en) begin
        en_cnt++; if (first_en < 0) first_en = cyc; last_en = cyc;
        if (addrq.size() > 0) begin
          chk("ram_addr", o_ram_addr, addrq.pop_front());
          availq.push_back(cyc + L + 1);
          outstanding++;
        end
      end
      if (o_data_valid) begin
        vld_cnt++; if (first_vld < 0) first_vld = cyc;
      end
      if (pop_now && expq.size() > 0) begin
        e = expq.pop_front();
        chk("data", o_data, e[DW-1:0]);
        chk("data_last", o_data_last, e[DW]);
        if (availq.size() > 0) void'(availq.pop_front());
        outstanding--;
        if (pop_cnt == 0) first_data = o_data;
        last_data = o_data; pop_cnt++;
        if (e[DW]) begin nd = 1; nb = 0; end
      end
      if (o_done) begin done_cnt++; done_cyc = cyc; end
      if (i_req_valid && o_req_ready) begin
        if (i_req_len == '0) nd = 1;
        else begin
          nb = 1;
          for (int i = 0; i < int'(i_req_len); i++) begin
            addrq.push_back(AW'(int'(i_req_addr) + i));
            expq.push_back({i == int'(i_req_len) - 1, ram[AW'(int'(i_req_addr) + i)]});
          end
        end
      end
      done_pend = nd; busy_m = nb;
    end
  end
  // consumer ready: 0 = always ready, 1 = random, 2 = held low
  int rmode = 0;
  initial begin
    i_data_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      i_data_ready = rmode == 0 ? 1'b1 : rmode == 2 ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_req(input int a, input int n, output int acc);
    i_req_addr = AW'(a); i_req_len = (AW+1)'(n); i_req_valid = 1'b1; acc = -1;
    for (int k = 0; k < 400 && acc < 0; k++) begin
      @(negedge clk);
      if (o_req_ready) acc = cyc;
    end
    if (acc < 0) begin
      checks++;
      $display("FAIL req_accept: got no acceptance expected within 400 cycles");
    end else @(posedge clk);
    #1;
    i_req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!o_busy && !o_data_valid) break;
    end
    if (k == 2000) begin
      checks++;
      $display("FAIL idle_wait: got busy expected idle within 2000 cycles");
    end
    wait_cycles(3);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ram_en"}, o_ram_en, 0);
    chk({tag, "_ram_addr"}, o_ram_addr, 0);
    chk({tag, "_valid"}, o_data_valid, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_last"}, o_data_last, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_req_ready"}, o_req_ready, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int e, e2;
    rst = 1'b1; i_req_valid = 1'b0; i_req_addr = '0; i_req_len = '0;
    clear_stats();
    wait_cycles(2);
    chk_reset_outputs("rst0");
    rst = 1'b0;
    wait_cycles(2);
    // full-rate burst, exact latency
    clear_stats();
    do_req(2, 4, e);
    wait_idle();
    chk("t1_first_en", first_en, e + 1);
    chk("t1_en_cnt", en_cnt, 4);
    chk("t1_last_en", last_en, e + 4);
    chk("t1_first_vld", first_vld, e + 5);
    chk("t1_first_data", first_data, 32'hA002);
    chk("t1_last_data", last_data, 32'hA005);
    chk("t1_done_cyc", done_cyc, e + 9);
    chk("t1_done_cnt", done_cnt, 1);
    // address wrap
    clear_stats();
    do_req(30, 4, e);
    wait_idle();
    chk("t2_first_data", first_data, 32'hA01E);
    chk("t2_last_data", last_data, 32'hA001);
    chk("t2_pop_cnt", pop_cnt, 4);
    // backpressure stall
    clear_stats();
    rmode = 2;
    do_req(0, 8, e);
    wait_cycles(9);
    chk("t3_stall_en_cnt", en_cnt, 4);
    chk("t3_head_valid", o_data_valid, 1);
    chk("t3_head_data", o_data, 32'hA000);
    chk("t3_no_pop", pop_cnt, 0);
    rmode = 0;
    wait_idle();
    chk("t3_pop_cnt", pop_cnt, 8);
    chk("t3_last_data", last_data, 32'hA007);
    // zero length
    clear_stats();
    do_req(7, 0, e);
    wait_cycles(4);
    chk("t4_en_cnt", en_cnt, 0);
    chk("t4_done_cyc", done_cyc, e + 1);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_vld_cnt", vld_cnt, 0);
    // back-to-back bursts
    clear_stats();
    do_req(5, 2, e);
    do_req(9, 3, e2);
    wait_idle();
    chk("t5_second_accept", e2, e + 7);
    chk("t5_first_data", first_data, 32'hA005);
    chk("t5_last_data", last_data, 32'hA00B);
    chk("t5_pop_cnt", pop_cnt, 5);
    chk("t5_done_cnt", done_cnt, 2);
    // reset mid-burst
    clear_stats();
    do_req(0, 6, e);
    wait_cycles(1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_rst");
    wait_cycles(2);
    rst = 1'b0;
    clear_stats();
    wait_cycles(10);
    chk("t6_vld_after", vld_cnt, 0);
    chk("t6_done_after", done_cnt, 0);
    chk("t6_en_after", en_cnt, 0);
    do_req(3, 2, e);
    wait_idle();
    chk("t6_new_first_vld", first_vld, e + 5);
    chk("t6_new_first_data", first_data, 32'hA003);
    chk("t6_new_pop_cnt", pop_cnt, 2);
    // randomized bursts with random backpressure
    rmode = 1;
    for (int n = 0; n < 40; n++) begin
      do_req($urandom_range(0, 31), $urandom_range(0, 20), e);
      if ($urandom_range(0, 1) != 0) wait_cycles($urandom_range(0, 3));
    end
    rmode = 0;
    wait_idle();
    chk("rand_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
